fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling FIFO directly downstream of the instruction-fetch stage.
- Captures each fetched {pc, instruction} pair and presents it, in order, to the decode stage over a valid/ready handshake.
- Back-pressures fetch through pcStall when full.
- Discards all buffered entries on a control-flow redirect (flush), so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CW, 3, width of occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous active-high reset
- fetchValid  input  1  fetch pc/instruction valid this cycle
- fetchPc  input  32  byte address of fetched instruction
- fetchInstruction  input  32  fetched instruction word
- pcStall  output  1  hold fetch PC; combinational
- flush  input  1  redirect in progress (same cycle fetch sees its jump request)
- decodeReady  input  1  decode accepts head entry this cycle
- decodeValid  output  1  head entry valid; combinational
- decodePc  output  32  head entry pc
- decodeInstruction  output  32  head entry instruction
- count  output  CW  current occupancy, registered

Behaviour:
- Storage: DEPTH x 64-bit array, read pointer, write pointer (log2(DEPTH) bits each, natural wrap), registered count.
- Reset (sync): read pointer = 0, write pointer = 0, count = 0. Array contents are don't-care.
- Output values after reset:
  - count = 0
  - decodeValid = 0
  - pcStall = 0
  - decodePc and decodeInstruction = array contents at index 0; no required value while decodeValid = 0.
- Reset mid-operation discards all entries; there is no partial drain.
- Combinational outputs:
  - full = (count == DEPTH)
  - pcStall = full AND NOT flush. Flush must release the stall because fetch gives stall priority over jump.
  - decodeValid = (count != 0) AND NOT flush
  - decodePc and decodeInstruction = array[read pointer], valid only when decodeValid = 1.
- Handshake qualifiers:
  - enq = fetchValid AND NOT full AND NOT flush
  - deq = decodeValid AND decodeReady
- Clock edge, non-flush cycle:
  - enq: write {fetchPc, fetchInstruction} at write pointer, then increment write pointer.
  - deq: increment read pointer.
  - count: +1 (enq only), -1 (deq only), unchanged (both or neither).
- Simultaneous enq and deq at any occupancy 1..DEPTH-1: both proceed and order is preserved.
- At full, deq and enq in the same cycle cannot both happen:
  - pcStall = 1 blocks enq.
  - The freed slot is usable on the next cycle.
  - No combinational path from decodeReady to pcStall.
- Empty: no bypass. An entry written in cycle N is visible to decode in cycle N+1 at the earliest. Minimum latency is 1 cycle; steady-state throughput is 1/cycle.
- Flush cycle:
  - No enq, no deq, decodeValid = 0.
  - Next edge: read pointer = write pointer = 0, count = 0.
  - The jump target fetched in cycle N+1 is enqueued normally.
- Flush and reset together: reset result, which is identical.
- fetchValid = 0: no enq; the queue drains normally.
- Overflow and underflow are impossible by construction. The bench asserts count never exceeds DEPTH and never wraps below 0.

Test Plan:
1. Reset:
   - Stimulus: reset high 2 cycles with fetchValid = 1.
   - Required: count = 0, decodeValid = 0, pcStall = 0 throughout; first enq occurs on the first cycle after reset is released.
2. Streaming:
   - Stimulus: fetchValid = 1, decodeReady = 1, pcs 0x3000, 0x3004, 0x3008.
   - Required: decodePc = 0x3000 one cycle after its enq, then 0x3004 and 0x3008 on consecutive cycles; count stays 1 in steady state; pcStall never asserts.
3. Fill and release:
   - Stimulus: decodeReady = 0, enqueue 0x3000..0x300C; then decodeReady = 1 for 1 cycle.
   - Required before release: count = 4, pcStall = 1, pc 0x3010 held and not enqueued.
   - Required after release: 0x3000 consumed, count = 3, pcStall = 0 next cycle, then 0x3010 enqueued.
4. Flush while full:
   - Stimulus: DEPTH entries buffered, flush = 1 for 1 cycle.
   - Required in the flush cycle: pcStall = 0, decodeValid = 0.
   - Required after: next cycle count = 0; jump target pc (e.g. 0x3040) appears at decode two cycles after flush; no stale entry ever shows decodeValid = 1.
5. Concurrent enq/deq at count = 2:
   - Stimulus: decodeReady = 1 and fetchValid = 1 for 5 cycles.
   - Required: count remains 2; decodePc sequence strictly increments by 4 with no duplicates and no gaps.
6. Reset mid-operation:
   - Stimulus: 3 entries buffered, reset = 1 for 1 cycle alongside decodeReady = 1.
   - Required: next cycle count = 0, decodeValid = 0; no entry is reported as consumed after reset.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order decoupling FIFO between instruction fetch and decode
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetchValid,
    input  logic [31:0]   fetchPc,
    input  logic [31:0]   fetchInstruction,
    output logic          pcStall,
    input  logic          flush,
    input  logic          decodeReady,
    output logic          decodeValid,
    output logic [31:0]   decodePc,
    output logic [31:0]   decodeInstruction,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, enq, deq;
    // Handshake qualifiers and head presentation; flush hides the head and releases the stall
    always_comb begin
        full = count_q == CW'(DEPTH);
        pcStall = full && !flush;
        decodeValid = (count_q != '0) && !flush;
        enq = fetchValid && !full && !flush;
        deq = decodeValid && decodeReady;
        {decodePc, decodeInstruction} = mem_q[rd_ptr_q];
        count = count_q;
    end
    // Next state: pointers wrap naturally, flush empties the queue in one edge
    always_comb begin
        mem_d = mem_q;
        if (enq) mem_d[wr_ptr_q] = {fetchPc, fetchInstruction};
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(enq);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(deq);
        count_d = flush ? '0 : count_q + CW'(enq) - CW'(deq);
    end
    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end
    // Entry storage needs no reset; only slots below count are ever presented
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW = 3;
    logic          clk = 1'b0;
    logic          reset, fetchValid, flush, decodeReady;
    logic [31:0]   fetchPc, fetchInstruction;
    logic          pcStall, decodeValid;
    logic [31:0]   decodePc, decodeInstruction;
    logic [CW-1:0] count;
    int            checks = 0;
    int            errors = 0;
    logic [63:0]   sb[$];
    logic [31:0]   o_pc, o_cnt, o_valid, o_stall;

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .fetchValid(fetchValid), .fetchPc(fetchPc),
        .fetchInstruction(fetchInstruction), .pcStall(pcStall), .flush(flush),
        .decodeReady(decodeReady), .decodeValid(decodeValid), .decodePc(decodePc),
        .decodeInstruction(decodeInstruction), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hbeef, ~pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, compare outputs against the queue model mid-cycle, then advance the model
    task automatic cyc(input logic r, input logic fv, input logic [31:0] pc,
                       input logic fl, input logic dr, input bit chk = 1'b1);
        logic ev, es, en, dq;
        reset = r; fetchValid = fv; fetchPc = pc; fetchInstruction = ins(pc);
        flush = fl; decodeReady = dr;
        #4;
        o_pc = decodePc; o_cnt = 32'(count); o_valid = 32'(decodeValid); o_stall = 32'(pcStall);
        ev = (sb.size() != 0) && !fl;
        es = (sb.size() == DEPTH) && !fl;
        en = fv && (sb.size() != DEPTH) && !fl && !r;
        dq = ev && dr && !r;
        if (chk) begin
            check("count", o_cnt, 32'(sb.size()));
            check("count_range", 32'(o_cnt <= DEPTH), 32'd1);
            check("decodeValid", o_valid, 32'(ev));
            check("pcStall", o_stall, 32'(es));
            if (ev) begin
                check("head_pc", o_pc, sb[0][63:32]);
                check("head_ins", decodeInstruction, sb[0][31:0]);
            end
        end
        if (r || fl) sb.delete();
        else begin
            if (dq) void'(sb.pop_front());
            if (en) sb.push_back({pc, ins(pc)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; fetchValid = 1'b0; flush = 1'b0; decodeReady = 1'b0;
        fetchPc = '0; fetchInstruction = '0;
        @(posedge clk);
        #1;
        cyc(1, 1, 32'h3000, 0, 0, 1'b0);
        // Reset held with fetch active
        cyc(1, 1, 32'h3000, 0, 0);
        cyc(1, 1, 32'h3000, 0, 0);
        check("t1_cnt", o_cnt, 32'd0);
        check("t1_stall", o_stall, 32'd0);
        // Streaming: first enq right after reset release
        cyc(0, 1, 32'h3000, 0, 1);
        check("t2_valid0", o_valid, 32'd0);
        cyc(0, 1, 32'h3004, 0, 1);
        check("t2_pc0", o_pc, 32'h3000);
        check("t2_cnt0", o_cnt, 32'd1);
        cyc(0, 1, 32'h3008, 0, 1);
        check("t2_pc1", o_pc, 32'h3004);
        check("t2_cnt1", o_cnt, 32'd1);
        cyc(0, 0, 32'h0, 0, 1);
        check("t2_pc2", o_pc, 32'h3008);
        // Fill and release
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h3000 + 32'(4 * i), 0, 0);
        cyc(0, 1, 32'h3010, 0, 0);
        check("t3_full_cnt", o_cnt, 32'd4);
        check("t3_full_stall", o_stall, 32'd1);
        cyc(0, 1, 32'h3010, 0, 1);
        check("t3_rel_pc", o_pc, 32'h3000);
        cyc(0, 1, 32'h3010, 0, 0);
        check("t3_after_cnt", o_cnt, 32'd3);
        check("t3_after_stall", o_stall, 32'd0);
        cyc(0, 0, 32'h0, 0, 0);
        check("t3_refill_cnt", o_cnt, 32'd4);
        // Flush while full
        cyc(0, 1, 32'h3020, 1, 0);
        check("t4_fl_stall", o_stall, 32'd0);
        check("t4_fl_valid", o_valid, 32'd0);
        cyc(0, 1, 32'h3040, 0, 0);
        check("t4_cnt", o_cnt, 32'd0);
        check("t4_valid", o_valid, 32'd0);
        cyc(0, 0, 32'h0, 0, 1);
        check("t4_target", o_pc, 32'h3040);
        cyc(0, 0, 32'h0, 0, 0);
        // Concurrent enq/deq at count 2
        cyc(0, 1, 32'h3100, 0, 0);
        cyc(0, 1, 32'h3104, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 32'h3108 + 32'(4 * i), 0, 1);
            check("t5_cnt", o_cnt, 32'd2);
            check("t5_pc", o_pc, 32'h3100 + 32'(4 * i));
        end
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 0, 0);
        check("t5_drained", o_cnt, 32'd0);
        // Reset mid-operation
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h3200 + 32'(4 * i), 0, 0);
        cyc(1, 0, 32'h0, 0, 1);
        check("t6_pre_cnt", o_cnt, 32'd3);
        cyc(0, 0, 32'h0, 0, 1);
        check("t6_cnt", o_cnt, 32'd0);
        check("t6_valid", o_valid, 32'd0);
        cyc(0, 0, 32'h0, 0, 1);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
